irq_ack_responder: RTL and testbench

- Testbench-side model of the core's interrupt-acknowledge interface.
- The perturbation interrupt generator raises irq/id. This block answers with a one-cycle acknowledge carrying the captured id.
- Acknowledge timing follows the perturbation mode: STANDARD, RANDOM, PC_TRIG or SOFTWARE_DEFINED.
- Lets the interrupt generator be verified standalone, with no core attached.

---
 rtl/irq_ack_responder_pkg.sv | 43 ++++
 rtl/irq_ack_responder_lfsr16.sv | 27 ++
 rtl/irq_ack_responder.sv | 148 ++++++++++++++
 tb/tb_irq_ack_responder.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/irq_ack_responder_pkg.sv
// Shared definitions for the interrupt-acknowledge responder: perturbation mode
// codes, FSM state encoding and the 16-bit LFSR step function.
package irq_ack_responder_pkg;

  localparam logic [31:0] PERT_MODE_STANDARD         = 32'd1;
  localparam logic [31:0] PERT_MODE_RANDOM           = 32'd2;
  localparam logic [31:0] PERT_MODE_PC_TRIG          = 32'd3;
  localparam logic [31:0] PERT_MODE_SOFTWARE_DEFINED = 32'd4;

  // Fibonacci taps for x^16+x^14+x^13+x^11+1 (state bits 15,13,12,10)
  localparam logic [15:0] LFSR16_TAPS = 16'hB400;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_ACK     = 2'd2,
    ST_HOLDOFF = 2'd3
  } ack_state_e;

  typedef enum logic [1:0] {
    RM_STANDARD = 2'd0,
    RM_RANDOM   = 2'd1,
    RM_PC_TRIG  = 2'd2,
    RM_SW       = 2'd3
  } req_mode_e;

  function automatic req_mode_e decode_mode(input logic [31:0] code);
    req_mode_e m;
    case (code)
      PERT_MODE_STANDARD:         m = RM_STANDARD;
      PERT_MODE_RANDOM:           m = RM_RANDOM;
      PERT_MODE_PC_TRIG:          m = RM_PC_TRIG;
      PERT_MODE_SOFTWARE_DEFINED: m = RM_SW;
      default:                    m = RM_STANDARD;
    endcase
    return m;
  endfunction

  function automatic logic [15:0] lfsr16_next(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR16_TAPS)};
  endfunction

endpackage

// File: rtl/irq_ack_responder_lfsr16.sv
// Seeded free-running 16-bit Fibonacci LFSR; advances on every non-reset cycle
// and exposes its low OUT_W bits as a random latency.
module perturbation_lfsr16
  import irq_ack_responder_pkg::*;
#(
  parameter logic [15:0] SEED  = 16'hACE1,
  parameter int unsigned OUT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  output logic [OUT_W-1:0] value_o
);

  logic [15:0] r_state;

  // Shift register update; the seed must be nonzero or the sequence locks up.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= SEED;
    end else begin
      r_state <= lfsr16_next(r_state);
    end
  end

  assign value_o = r_state[OUT_W-1:0];

endmodule

// File: rtl/irq_ack_responder.sv
// Interrupt-acknowledge responder: captures a request from the perturbation
// generator and answers with a one-cycle ack whose timing follows the mode.
module irq_ack_responder
  import irq_ack_responder_pkg::*;
#(
  parameter int unsigned IRQ_ID_W  = 5,
  parameter int unsigned LAT_W     = 8,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                enable_i,
  input  logic [31:0]         mode_i,
  input  logic [LAT_W-1:0]    fixed_lat_i,
  input  logic [31:0]         pc_i,
  input  logic [31:0]         pc_trig_i,
  input  logic                sw_ack_i,
  input  logic                irq_i,
  input  logic [IRQ_ID_W-1:0] irq_id_i,
  output logic                irq_ack_o,
  output logic [IRQ_ID_W-1:0] irq_ack_id_o,
  output logic                busy_o,
  output logic                spurious_o,
  output logic [15:0]         ack_count_o
);

  localparam logic [LAT_W-1:0] CNT_ZERO  = {LAT_W{1'b0}};
  localparam logic [LAT_W-1:0] CNT_ONE   = {{(LAT_W-1){1'b0}}, 1'b1};
  localparam logic [15:0]      ACK_MAX   = 16'hFFFF;
  localparam logic [15:0]      ACK_ONE   = 16'h0001;

  ack_state_e          r_state;
  req_mode_e           r_mode;
  logic [IRQ_ID_W-1:0] r_id;
  logic [LAT_W-1:0]    r_cnt;
  logic                r_ack;
  logic [IRQ_ID_W-1:0] r_ack_id;
  logic                r_busy;
  logic                r_spurious;
  logic [15:0]         r_ack_count;

  logic [LAT_W-1:0]    w_lfsr_lat;
  req_mode_e           w_req_mode;
  logic [LAT_W-1:0]    w_load_lat;
  logic                w_exit;
  logic                w_cnt_mode;
  logic [15:0]         w_ack_count_next;

  perturbation_lfsr16 #(
    .SEED  (LFSR_SEED),
    .OUT_W (LAT_W)
  ) u_lfsr (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .value_o (w_lfsr_lat)
  );

  assign w_req_mode = decode_mode(mode_i);
  assign w_cnt_mode = (r_mode == RM_STANDARD) || (r_mode == RM_RANDOM);
  assign w_ack_count_next = (r_ack_count == ACK_MAX) ? r_ack_count : r_ack_count + ACK_ONE;

  // Latency loaded at capture time; event-driven modes leave the counter idle.
  always_comb begin
    w_load_lat = CNT_ZERO;
    case (w_req_mode)
      RM_STANDARD: w_load_lat = fixed_lat_i;
      RM_RANDOM:   w_load_lat = w_lfsr_lat;
      default:     w_load_lat = CNT_ZERO;
    endcase
  end

  // WAIT exit condition, evaluated against the mode frozen at capture.
  always_comb begin
    w_exit = 1'b0;
    case (r_mode)
      RM_STANDARD: w_exit = (r_cnt == CNT_ZERO);
      RM_RANDOM:   w_exit = (r_cnt == CNT_ZERO);
      RM_PC_TRIG:  w_exit = (pc_i == pc_trig_i);
      RM_SW:       w_exit = sw_ack_i;
      default:     w_exit = 1'b0;
    endcase
  end

  // Request FSM with registered outputs; abort paths take priority over the ack.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= ST_IDLE;
      r_mode      <= RM_STANDARD;
      r_id        <= {IRQ_ID_W{1'b0}};
      r_cnt       <= CNT_ZERO;
      r_ack       <= 1'b0;
      r_ack_id    <= {IRQ_ID_W{1'b0}};
      r_busy      <= 1'b0;
      r_spurious  <= 1'b0;
      r_ack_count <= 16'h0000;
    end else begin
      r_ack      <= 1'b0;
      r_ack_id   <= {IRQ_ID_W{1'b0}};
      r_spurious <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (enable_i && irq_i) begin
            r_id    <= irq_id_i;
            r_mode  <= w_req_mode;
            r_cnt   <= w_load_lat;
            r_busy  <= 1'b1;
            r_state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (!enable_i) begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else if (!irq_i) begin
            r_spurious <= 1'b1;
            r_busy     <= 1'b0;
            r_state    <= ST_IDLE;
          end else if (w_exit) begin
            r_ack       <= 1'b1;
            r_ack_id    <= r_id;
            r_ack_count <= w_ack_count_next;
            r_state     <= ST_ACK;
          end else if (w_cnt_mode) begin
            r_cnt <= r_cnt - CNT_ONE;
          end
        end
        ST_ACK: begin
          r_busy  <= 1'b0;
          r_state <= ST_HOLDOFF;
        end
        ST_HOLDOFF: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign irq_ack_o    = r_ack;
  assign irq_ack_id_o = r_ack_id;
  assign busy_o       = r_busy;
  assign spurious_o   = r_spurious;
  assign ack_count_o  = r_ack_count;

endmodule

// File: tb/tb_irq_ack_responder.sv
// Directed self-checking bench for irq_ack_responder with an independent
// LFSR reference for the random-latency mode.
module tb_irq_ack_responder;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        enable_i;
  logic [31:0] mode_i;
  logic [7:0]  fixed_lat_i;
  logic [31:0] pc_i;
  logic [31:0] pc_trig_i;
  logic        sw_ack_i;
  logic        irq_i;
  logic [4:0]  irq_id_i;
  logic        irq_ack_o;
  logic [4:0]  irq_ack_id_o;
  logic        busy_o;
  logic        spurious_o;
  logic [15:0] ack_count_o;

  int          n_vec = 0;
  int          n_err = 0;
  logic [15:0] m_lfsr;
  logic [15:0] exp_count;

  irq_ack_responder #(
    .IRQ_ID_W  (5),
    .LAT_W     (8),
    .LFSR_SEED (16'hACE1)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .enable_i     (enable_i),
    .mode_i       (mode_i),
    .fixed_lat_i  (fixed_lat_i),
    .pc_i         (pc_i),
    .pc_trig_i    (pc_trig_i),
    .sw_ack_i     (sw_ack_i),
    .irq_i        (irq_i),
    .irq_id_i     (irq_id_i),
    .irq_ack_o    (irq_ack_o),
    .irq_ack_id_o (irq_ack_id_o),
    .busy_o       (busy_o),
    .spurious_o   (spurious_o),
    .ack_count_o  (ack_count_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference LFSR: x^16+x^14+x^13+x^11+1, taps at state bits 15,13,12,10
  always @(posedge clk_i) begin
    if (rst_i) m_lfsr <= 16'hACE1;
    else       m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic capture(input logic [31:0] mode, input logic [7:0] lat, input logic [4:0] id,
                         output logic [7:0] rnd_lat);
    mode_i      = mode;
    fixed_lat_i = lat;
    irq_id_i    = id;
    irq_i       = 1'b1;
    rnd_lat     = m_lfsr[7:0];
    tick();
  endtask

  task automatic wait_ack(input int budget, input logic [31:0] pc_step, output int k,
                          output logic [4:0] id);
    k  = -1;
    id = 5'd0;
    for (int c = 1; c <= budget; c++) begin
      pc_i = pc_i + pc_step;
      tick();
      if (irq_ack_o) begin
        k  = c;
        id = irq_ack_id_o;
        break;
      end
    end
  endtask

  task automatic finish_ack();
    irq_i = 1'b0;
    tick();
    chk("holdoff_ack", {31'd0, irq_ack_o}, 32'd0);
    chk("holdoff_busy", {31'd0, busy_o}, 32'd0);
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int         k;
    logic [4:0] id;
    logic [7:0] rl;

    rst_i = 1'b1; enable_i = 1'b1; mode_i = 32'd1; fixed_lat_i = 8'd0;
    pc_i = 32'h1C00_0000; pc_trig_i = 32'h1C00_0080; sw_ack_i = 1'b0;
    irq_i = 1'b0; irq_id_i = 5'd0; exp_count = 16'd0;
    repeat (3) tick();
    chk("rst_ack", {31'd0, irq_ack_o}, 32'd0);
    chk("rst_id", {27'd0, irq_ack_id_o}, 32'd0);
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    chk("rst_spur", {31'd0, spurious_o}, 32'd0);
    chk("rst_cnt", {16'd0, ack_count_o}, 32'd0);
    rst_i = 1'b0;
    tick();

    // STANDARD lat 3, id 5; id changes during WAIT must be ignored
    capture(32'd1, 8'd3, 5'd5, rl);
    chk("std_busy", {31'd0, busy_o}, 32'd1);
    irq_id_i = 5'd9;
    wait_ack(20, 32'd0, k, id);
    chk("std_lat", k, 32'd4);
    chk("std_id", {27'd0, id}, 32'd5);
    chk("std_ack_busy", {31'd0, busy_o}, 32'd1);
    exp_count = exp_count + 16'd1;
    chk("std_count", {16'd0, ack_count_o}, {16'd0, exp_count});
    finish_ack();

    // STANDARD lat 0 and an unknown mode code treated as STANDARD
    capture(32'd1, 8'd0, 5'd17, rl);
    wait_ack(10, 32'd0, k, id);
    chk("lat0", k, 32'd1);
    chk("lat0_id", {27'd0, id}, 32'd17);
    exp_count = exp_count + 16'd1;
    finish_ack();
    capture(32'd7, 8'd2, 5'd3, rl);
    wait_ack(10, 32'd0, k, id);
    chk("badmode_lat", k, 32'd3);
    exp_count = exp_count + 16'd1;
    finish_ack();

    // Maximum latency 255 must not wrap
    capture(32'd1, 8'd255, 5'd31, rl);
    wait_ack(300, 32'd0, k, id);
    chk("maxlat", k, 32'd256);
    exp_count = exp_count + 16'd1;
    finish_ack();

    // PC_TRIG: pc steps by 4 from 0x1C000000, trigger at 0x1C000080
    pc_i = 32'h1C00_0000;
    capture(32'd3, 8'd0, 5'd12, rl);
    wait_ack(60, 32'd4, k, id);
    chk("pc_lat", k, 32'd32);
    chk("pc_at_ack", pc_i, 32'h1C00_0080);
    chk("pc_id", {27'd0, id}, 32'd12);
    exp_count = exp_count + 16'd1;
    finish_ack();

    // SOFTWARE_DEFINED: no ack without sw_ack_i even after mode changes to STANDARD
    capture(32'd4, 8'd0, 5'd21, rl);
    mode_i = 32'd1;
    wait_ack(50, 32'd0, k, id);
    chk("sw_noack", k, 32'hFFFF_FFFF);
    sw_ack_i = 1'b1;
    tick();
    sw_ack_i = 1'b0;
    chk("sw_ack", {31'd0, irq_ack_o}, 32'd1);
    chk("sw_id", {27'd0, irq_ack_id_o}, 32'd21);
    exp_count = exp_count + 16'd1;
    finish_ack();

    // Withdrawal after 4 WAIT cycles: one spurious pulse, no ack
    capture(32'd1, 8'd10, 5'd6, rl);
    wait_ack(4, 32'd0, k, id);
    chk("wd_noack", k, 32'hFFFF_FFFF);
    irq_i = 1'b0;
    tick();
    chk("wd_spur", {31'd0, spurious_o}, 32'd1);
    chk("wd_busy", {31'd0, busy_o}, 32'd0);
    chk("wd_ack", {31'd0, irq_ack_o}, 32'd0);
    tick();
    chk("wd_spur_once", {31'd0, spurious_o}, 32'd0);

    // Same, but enable_i dropped instead: silent abort
    capture(32'd1, 8'd10, 5'd6, rl);
    wait_ack(4, 32'd0, k, id);
    enable_i = 1'b0;
    tick();
    chk("en_spur", {31'd0, spurious_o}, 32'd0);
    chk("en_busy", {31'd0, busy_o}, 32'd0);
    wait_ack(15, 32'd0, k, id);
    chk("en_noack", k, 32'hFFFF_FFFF);
    irq_i = 1'b0;
    tick();
    enable_i = 1'b1;
    tick();
    chk("en_count", {16'd0, ack_count_o}, {16'd0, exp_count});

    // RANDOM: 100 back-to-back requests against the reference LFSR
    for (int i = 0; i < 100; i++) begin
      logic [31:0] exp_k;
      capture(32'd2, 8'd0, i[4:0], rl);
      exp_k = {24'd0, rl} + 32'd1;
      wait_ack(300, 32'd0, k, id);
      chk("rnd_lat", k, exp_k);
      chk("rnd_id", {27'd0, id}, {27'd0, i[4:0]});
      exp_count = exp_count + 16'd1;
      finish_ack();
    end
    chk("rnd_count", {16'd0, ack_count_o}, {16'd0, exp_count});

    // Reset mid-WAIT discards the request and clears everything
    capture(32'd1, 8'd20, 5'd9, rl);
    wait_ack(3, 32'd0, k, id);
    rst_i = 1'b1;
    irq_i = 1'b0;
    tick();
    chk("mrst_ack", {31'd0, irq_ack_o}, 32'd0);
    chk("mrst_busy", {31'd0, busy_o}, 32'd0);
    chk("mrst_spur", {31'd0, spurious_o}, 32'd0);
    chk("mrst_cnt", {16'd0, ack_count_o}, 32'd0);
    rst_i = 1'b0;
    tick();
    wait_ack(30, 32'd0, k, id);
    chk("mrst_noack", k, 32'hFFFF_FFFF);

    // Saturation of the acknowledge counter
    force dut.r_ack_count = 16'hFFFD;
    #1;
    release dut.r_ack_count;
    capture(32'd1, 8'd0, 5'd1, rl);
    wait_ack(10, 32'd0, k, id);
    chk("sat_1", {16'd0, ack_count_o}, 32'h0000_FFFE);
    finish_ack();
    capture(32'd1, 8'd0, 5'd2, rl);
    wait_ack(10, 32'd0, k, id);
    chk("sat_2", {16'd0, ack_count_o}, 32'h0000_FFFF);
    finish_ack();
    capture(32'd1, 8'd0, 5'd3, rl);
    wait_ack(10, 32'd0, k, id);
    chk("sat_3_ack", k, 32'd1);
    chk("sat_3", {16'd0, ack_count_o}, 32'h0000_FFFF);
    finish_ack();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
